instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Packs RISC-V instruction fields and an immediate into a 32-bit instruction word. This is the inverse of the core's immediate generator.
- Sits between the test/program loader and instruction memory.
- Registered, one-deep pipeline stage with valid/ready handshakes on both sides.
- Tags each word with a sequential memory address and flags out-of-range immediates.

Parameters:
- DEPTH, 256: number of words accepted before the block reports full.
- ADDR_W, 32: width of out_addr.
- BASE_ADDR, 0: byte address of the first word.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- restart  input  1  single-cycle pulse; rewinds the address counter and clears full
- in_valid  input  1  field set present
- in_ready  output  1  block can accept this cycle
- in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- in_opcode  input  7  opcode bits [6:0]
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R only)
- in_imm  input  32  immediate, in the same form the immediate generator outputs
- out_valid  output  1  encoded word present
- out_ready  input  1  consumer accepts word
- out_instr  output  32  encoded instruction
- out_addr  output  ADDR_W  byte address of out_instr
- out_err  output  1  immediate out of range, or illegal fmt
- full  output  1  DEPTH words accepted since reset/restart
- err_count  output  8  saturating count of erroneous words accepted

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, full=0, err_count=0, index=0.
- in_ready = !restart && !full && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
- Output handoff = out_valid && out_ready.
- Latency: an accept at edge N gives out_valid=1 after edge N, holding the encoded word.
- out_instr, out_addr and out_err stay stable while out_valid && !out_ready.
- Handoff without a simultaneous accept clears out_valid. Handoff with an accept loads the new word; no bubble.
- Packing, with opcode always in [6:0]:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: inst[31]=imm[11], inst[7]=imm[10], inst[30:25]=imm[9:4], inst[11:8]=imm[3:0]; rs2, rs1, funct3 in their usual positions. The imm input is the half-word offset.
  - U: {imm[31:12], rd, opcode}.
  - J: inst[31]=imm[19], inst[19:12]=imm[18:11], inst[20]=imm[10], inst[30:21]=imm[9:0]; rd and opcode in their usual positions.
- Range check sets out_err=1 when:
  - I/S/B: imm[31:12] is not all equal to imm[11].
  - J: imm[31:20] is not all equal to imm[19].
  - U: imm[11:0] is not zero.
  - R: in_imm is ignored; no error.
  - fmt 6/7: always an error.
- On error: out_instr=0; the word is still emitted and still consumes an address; err_count increments, saturating at 255.
- Addressing:
  - out_addr = BASE_ADDR + 4*index, modulo 2^ADDR_W.
  - index increments on each accept.
  - When index reaches DEPTH: full=1 and in_ready=0. Pending output still drains.
- restart:
  - index=0, full=0, next address BASE_ADDR.
  - in_ready is 0 in the restart cycle, so there is no accept.
  - An in-flight out_valid word is kept and still drains.
  - err_count is not cleared by restart.
- rst mid-operation discards any pending word immediately.

Test Plan:
- R add x3,x1,x2 (op 0110011, f7=0, f3=0) -> out_instr=0x002081B3, out_addr=0x0, out_err=0, one cycle after accept.
- I addi x5,x0,imm=0xFFFFFFFF (op 0010011) -> 0xFFF00293. Then imm=0x00000800 -> out_err=1, out_instr=0, err_count=1.
- B beq x1,x2, imm=0x00000008 (op 1100011) -> 0x00208863. Every R/I/S/B/U/J output, fed to the immediate generator, reproduces in_imm.
- out_ready held low 3 cycles with in_valid high -> in_ready=0, out_instr/out_addr stable; on release, back-to-back words with no bubble.
- DEPTH=4: four accepts -> addresses 0x0, 0x4, 0x8, 0xC, then full=1 and in_ready=0. restart -> full=0; next word at 0x0; err_count unchanged.
- rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_addr=BASE_ADDR, err_count=0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Handshake bundle between the program loader, the instruction encoder and instruction memory.
// The slave view belongs to the encoder; the master view belongs to the loader/memory side.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs RISC-V fields plus an immediate into a 32-bit word, tags it with a sequential
// byte address and flags out-of-range immediates; one registered valid/ready stage.
module instr_encoder #(
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    instr_encoder_if.slave        bus,
    output logic                  full,
    output logic [7:0]            err_count
);
    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic              out_err_q,   out_err_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [IDX_W-1:0]  index_q,     index_d;
    logic              full_q,      full_d;
    logic [7:0]        err_count_q, err_count_d;

    logic              ready;
    logic              accept;
    logic              handoff;
    logic [IDX_W-1:0]  index_inc;
    logic [31:0]       enc_instr;
    logic              enc_err;
    logic [31:0]       imm;

    // B and J take the immediate as a half-word offset, so imm[0] lands in the word directly.
    always_comb begin
        imm       = bus.in_imm;
        enc_instr = '0;
        enc_err   = 1'b0;
        case (fmt_e'(bus.in_fmt))
            FMT_R: enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                bus.in_rd, bus.in_opcode};
            FMT_I: begin
                enc_err   = (imm[31:12] != {20{imm[11]}});
                enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            end
            FMT_S: begin
                enc_err   = (imm[31:12] != {20{imm[11]}});
                enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[4:0], bus.in_opcode};
            end
            FMT_B: begin
                enc_err   = (imm[31:12] != {20{imm[11]}});
                enc_instr = {imm[11], imm[9:4], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[3:0], imm[10], bus.in_opcode};
            end
            FMT_U: begin
                enc_err   = (imm[11:0] != 12'd0);
                enc_instr = {imm[31:12], bus.in_rd, bus.in_opcode};
            end
            FMT_J: begin
                enc_err   = (imm[31:20] != {12{imm[19]}});
                enc_instr = {imm[19], imm[9:0], imm[10], imm[18:11], bus.in_rd, bus.in_opcode};
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_instr = '0;
        end
    end

    always_comb begin
        ready     = !restart && !full_q && (!out_valid_q || bus.out_ready);
        accept    = bus.in_valid && ready;
        handoff   = out_valid_q && bus.out_ready;
        index_inc = index_q + IDX_W'(1);

        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        next_addr_d = next_addr_q;
        index_d     = index_q;
        full_d      = full_q;
        err_count_d = err_count_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_addr_d  = next_addr_q;
            out_err_d   = enc_err;
            next_addr_d = next_addr_q + ADDR_W'(4);
            index_d     = index_inc;
            full_d      = (index_inc == IDX_W'(DEPTH));
            if (enc_err && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (handoff) begin
            out_valid_d = 1'b0;
        end

        // Restart never coincides with an accept, so it only rewinds the counters.
        if (restart) begin
            index_d     = '0;
            full_d      = 1'b0;
            next_addr_d = BASE_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= 1'b0;
            next_addr_q <= BASE_ADDR;
            index_q     <= '0;
            full_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            next_addr_q <= next_addr_d;
            index_q     <= index_d;
            full_q      <= full_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_err   = out_err_q;
    assign full          = full_q;
    assign err_count     = err_count_q;
endmodule
